// File: rtl/xc_aesmix_seq.sv
// xc_aesmix_seq
// Applies AES MixColumns (enc = 1) or InvMixColumns (enc = 0) to a full
// 128-bit AES state by streaming its four 32-bit columns, one at a time,
// through a shared single-column mix unit and collecting the results.
//
// Handshakes: a transfer on req_* happens on a clock edge where req_valid
// and req_ready are both 1; a transfer on rsp_* happens on an edge where
// rsp_valid and rsp_ready are both 1. Once raised, rsp_valid, rsp_state and
// rsp_err hold stable until that transfer (or an abort). The mix unit side
// is a single-beat request: mix_valid stays high with stable operands until
// an edge on which mix_ready is 1.
//
// Ports:
//   clock, resetn            clock, asynchronous active-low reset
//   req_valid/ready/state/enc request channel (column c = bits [32c+31:32c])
//   abort                     cancel the in-flight operation
//   rsp_valid/ready/state/err response channel (err = timeout, state = 0)
//   busy                      controller is not idle
//   mix_flush, mix_fdata      flush strobe and (zero) flush data for the unit
//   mix_valid, mix_rs1/rs2    current column operands for the unit
//   mix_enc                   direction for the unit
//   mix_ready, mix_result     unit result strobe and data
//
// Parameters:
//   TIMEOUT  max RUN cycles per column before aborting with error (>= 4)
//   TW       width of the wait counter; 2**TW must exceed TIMEOUT
module xc_aesmix_seq #(
    parameter int TIMEOUT = 15,
    parameter int TW      = 4
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [127:0] req_state,
    input  logic         req_enc,
    input  logic         abort,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_state,
    output logic         rsp_err,
    output logic         busy,
    output logic         mix_flush,
    output logic [31:0]  mix_fdata,
    output logic         mix_valid,
    output logic [31:0]  mix_rs1,
    output logic [31:0]  mix_rs2,
    output logic         mix_enc,
    input  logic         mix_ready,
    input  logic [31:0]  mix_result
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FLUSH = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     col_q;
    logic [TW-1:0]  cnt_q;
    logic [127:0]   buf_q;
    logic           enc_q;
    logic           err_q;

    logic [31:0]    col_word;
    logic           timeout_hit;

    assign col_word    = buf_q[{col_q, 5'b0} +: 32];
    assign timeout_hit = (cnt_q == TW'(TIMEOUT - 1)) && !mix_ready;

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort wins over mix_ready and rsp_ready
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                if (abort) state_d = S_IDLE;
                else       state_d = S_RUN;
            end
            S_RUN: begin
                if (abort)            state_d = S_IDLE;
                else if (mix_ready)   state_d = (col_q == 2'd3) ? S_DONE : S_FLUSH;
                else if (timeout_hit) state_d = S_DONE;
            end
            S_DONE: begin
                if (abort || rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath registers: captured state, column index, wait counter, flags
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            col_q <= 2'd0;
            cnt_q <= '0;
            buf_q <= '0;
            enc_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        buf_q <= req_state;
                        enc_q <= req_enc;
                        col_q <= 2'd0;
                    end
                end
                S_FLUSH: begin
                    if (abort) begin
                        buf_q <= '0;
                        err_q <= 1'b0;
                    end else begin
                        cnt_q <= '0;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        buf_q <= '0;
                        err_q <= 1'b0;
                    end else if (mix_ready) begin
                        buf_q[{col_q, 5'b0} +: 32] <= mix_result;
                        if (col_q != 2'd3) col_q <= col_q + 2'd1;
                    end else if (timeout_hit) begin
                        // Partial results are meaningless after a timeout
                        err_q <= 1'b1;
                        buf_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (abort) begin
                        buf_q <= '0;
                        err_q <= 1'b0;
                    end else if (rsp_ready) begin
                        err_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs: everything towards the mix unit is zero outside RUN so the
    // unit never sees stale operands.
    always_comb begin
        req_ready = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        rsp_valid = (state_q == S_DONE);
        rsp_state = (state_q == S_DONE) ? buf_q : 128'd0;
        rsp_err   = (state_q == S_DONE) && err_q;
        // An abort also flushes the unit so a half-done column is dropped
        mix_flush = (state_q == S_FLUSH) || (abort && (state_q != S_IDLE));
        mix_fdata = 32'd0;
        mix_valid = (state_q == S_RUN);
        mix_rs1   = (state_q == S_RUN) ? col_word : 32'd0;
        mix_rs2   = (state_q == S_RUN) ? col_word : 32'd0;
        mix_enc   = (state_q == S_RUN) && enc_q;
    end

endmodule

// File: doc/xc_aesmix_seq.md
Name: xc_aesmix_seq

Overview:
- Controller that applies AES MixColumns or InvMixColumns to a full 128-bit AES state.
- Feeds the four 32-bit columns one at a time into a shared single-column mix unit and collects the four results.
- Sits between the AES round sequencer and the mix unit.
- Works with both the single-cycle and the 4-cycle mix unit build, because it waits on the unit's ready.

Parameters:
- TIMEOUT, default 15: maximum RUN cycles per column before the operation is aborted with an error; must be at least 4.
- TW, default 4: width of the per-column wait counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clock       in   1    system clock
- resetn      in   1    reset; asynchronous, active-low
- req_valid   in   1    request present
- req_ready   out  1    controller can accept a request
- req_state   in   128  AES state; column c = req_state[32c+31:32c]; byte r of a column = bits [8r+7:8r]
- req_enc     in   1    1 = MixColumns, 0 = InvMixColumns
- abort       in   1    cancel the in-flight operation
- rsp_valid   out  1    result present
- rsp_ready   in   1    consumer accepts the result
- rsp_state   out  128  mixed state, same column packing as req_state
- rsp_err     out  1    qualifies rsp_valid; 1 = timeout, rsp_state = 0
- busy        out  1    state != IDLE
- mix_flush   out  1    flush strobe to the mix unit
- mix_fdata   out  32   flush data; constant 0
- mix_valid   out  1    mix unit inputs valid
- mix_rs1     out  32   current column word
- mix_rs2     out  32   current column word (same value as mix_rs1)
- mix_enc     out  1    registered req_enc
- mix_ready   in   1    mix unit result valid
- mix_result  in   32   mix unit result

Behaviour:
- States: IDLE, FLUSH, RUN, DONE. Other registers: col (2 bits), wait counter (TW bits), state_buf (128 bits), enc_q, err_q.
- Reset (resetn low, asynchronous):
  - state = IDLE, col = 0, counter = 0, state_buf = 0, enc_q = 0, err_q = 0.
  - Outputs: req_ready = 1, rsp_valid = 0, rsp_err = 0, rsp_state = 0, busy = 0, all mix_* = 0.
- IDLE:
  - req_ready = 1.
  - On req_valid: capture req_state into state_buf and req_enc into enc_q; col = 0; go to FLUSH.
- FLUSH (exactly 1 cycle):
  - mix_flush = 1, mix_valid = 0.
  - Next state: RUN, counter = 0.
- RUN:
  - mix_valid = 1; mix_rs1 = mix_rs2 = state_buf[32col+31:32col]; mix_enc = enc_q.
  - mix_rs1, mix_rs2 and mix_enc are 0 in every state except RUN.
  - On a clock edge with mix_ready = 1: write mix_result into column col of state_buf.
    - If col = 3, go to DONE.
    - Otherwise col increments and the next state is FLUSH.
  - On an edge with mix_ready = 0: counter increments.
  - If counter = TIMEOUT-1 and mix_ready = 0: set err_q, clear state_buf, go to DONE.
- DONE:
  - rsp_valid = 1; rsp_state = state_buf; rsp_err = err_q.
  - Both are held stable until rsp_ready; on rsp_ready go to IDLE and clear err_q.
  - rsp_state is 0 outside DONE.
- Latency from the acceptance edge to rsp_valid:
  - Single-cycle mix unit (mix_ready = mix_valid): 8 cycles.
  - 4-cycle mix unit: 20 cycles.
- abort in FLUSH, RUN or DONE:
  - Next state is IDLE, state_buf and err_q are cleared, and mix_flush = 1 in that cycle.
  - No response is produced; a pending response in DONE is discarded.
  - abort takes priority over mix_ready and over rsp_ready.
  - abort in IDLE has no effect, and the request offered in that cycle is still accepted.
- A new request is accepted only in IDLE, so there is no back-to-back overlap; minimum request spacing is 10 cycles with the single-cycle unit.
- A mix_ready arriving in FLUSH or IDLE is ignored.
- Reset asserted mid-operation returns everything to reset values immediately; no response is issued.

Test Plan:
- Encrypt: req_state = {0x01010101, 0xc6c6c6c6, 0x5c220af2, 0x455313db}, req_enc = 1, single-cycle unit -> rsp_state = {0x01010101, 0xc6c6c6c6, 0x9d58dc9f, 0xbca14d8e}, rsp_err = 0, rsp_valid 8 cycles after acceptance.
- Decrypt: feed the result above with req_enc = 0 -> the original state is returned; with the 4-cycle unit rsp_valid comes 20 cycles after acceptance, and exactly 4 mix_flush pulses are observed.
- Backpressure: hold rsp_ready = 0 for 5 cycles -> rsp_valid, rsp_state and rsp_err stay stable and req_ready stays 0; a req_valid in that window is not accepted.
- Timeout: tie mix_ready = 0 -> DONE after 1 + TIMEOUT cycles (16 at default) with rsp_err = 1 and rsp_state = 0; the next request then completes normally.
- Abort: assert abort during RUN of column 2 -> IDLE next cycle, mix_flush = 1 in that cycle, no rsp_valid; a following request produces correct results.
- Reset: deassert resetn asynchronously mid-RUN -> all outputs at reset values before the next clock edge; after release, req_ready = 1.
